// File: rtl/imm_rotate_encoder.sv
// -----------------------------------------------------------------------------
// imm_rotate_encoder
//   Searches for a {rot[3:0], imm8[7:0]} encoding of a 32-bit constant so that
//   imm8 ROR (2*rot) reproduces the constant exactly. One rotation is tested per
//   cycle, lowest rotation first. Constants with no encoding are flagged with
//   found=0.
//
//   The candidate is held in a register that is loaded with the captured value
//   and then rotated left by two bits per step. After r steps it holds
//   value ROL (2*r), so no barrel shifter is needed. The load cycle is the
//   first SEARCH cycle, which gives done two cycles after start on a rotation-0
//   hit and 17 cycles after start when no encoding exists.
//
//   Optional feature (compile-time macro IMM_ENC_NEG_EN):
//     defined   - each step also tests the bitwise inverse of the candidate,
//                 for MVN-style encodings; a positive hit wins at equal rotation
//                 and `inverted` reports that the encoding is of ~value.
//     undefined - only the value itself is tested and `inverted` is tied low.
// -----------------------------------------------------------------------------
module imm_rotate_encoder #(
    parameter int DATA_W = 32,   // operand width; only 32 is supported
    parameter int IMM_W  = 8,    // immediate field width
    parameter int ROT_W  = 4     // rotate field width
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DATA_W-1:0]        value,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [ROT_W+IMM_W-1:0]   enc,
    output logic                     imm_carry,
    output logic                     inverted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [ROT_W-1:0] ROT_LAST = '1;

    state_t              state_q;
    state_t              state_d;

    logic [DATA_W-1:0]   v_q;        // captured constant
    logic [DATA_W-1:0]   c_q;        // v_q ROL (2*r_q) once loaded_q is set
    logic [ROT_W-1:0]    r_q;        // rotation currently under test
    logic                loaded_q;   // candidate register holds rotation r_q

    logic                accept;
    logic                pos_hit;
    logic                neg_hit;
    logic                last_rot;
    logic                search_end;

    // A start is only honoured while idle; requests during SEARCH or DONE are dropped.
    assign accept   = (state_q == ST_IDLE) && start;

    // The candidate fits the immediate field when every bit above it is zero.
    assign pos_hit  = loaded_q && (c_q[DATA_W-1:IMM_W] == '0);

`ifdef IMM_ENC_NEG_EN
    // ~c_q equals (~v_q) ROL (2*r_q), so the inverse needs no second rotator.
    assign neg_hit  = loaded_q && (&c_q[DATA_W-1:IMM_W]);
`else
    assign neg_hit  = 1'b0;
`endif

    assign last_rot   = (r_q == ROT_LAST);
    assign search_end = pos_hit || neg_hit || (loaded_q && last_rot);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state decode plus the state-derived busy/done flags.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                busy = 1'b1;
                if (search_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture, candidate rotation and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q       <= '0;
            c_q       <= '0;
            r_q       <= '0;
            loaded_q  <= 1'b0;
            found     <= 1'b0;
            enc       <= '0;
            imm_carry <= 1'b0;
        end else if (accept) begin
            // New request: capture the constant and clear the previous result.
            v_q       <= value;
            r_q       <= '0;
            loaded_q  <= 1'b0;
            found     <= 1'b0;
            enc       <= '0;
            imm_carry <= 1'b0;
        end else if (state_q == ST_SEARCH) begin
            if (!loaded_q) begin
                // First search cycle: candidate for rotation 0 is the value itself.
                c_q      <= v_q;
                loaded_q <= 1'b1;
            end else if (pos_hit) begin
                found     <= 1'b1;
                enc       <= {r_q, c_q[IMM_W-1:0]};
                // The decoder's shifter carry is bit 31 of the result, except for
                // rotation 0 where no shift happens and the carry stays clear.
                imm_carry <= (r_q != '0) & v_q[DATA_W-1];
            end else if (neg_hit) begin
                found     <= 1'b1;
                enc       <= {r_q, ~c_q[IMM_W-1:0]};
                imm_carry <= (r_q != '0) & ~v_q[DATA_W-1];
            end else if (!last_rot) begin
                r_q <= r_q + 1'b1;
                c_q <= {c_q[DATA_W-3:0], c_q[DATA_W-1:DATA_W-2]};
            end
        end
    end

`ifdef IMM_ENC_NEG_EN
    // Flags a result that encodes ~value; a positive hit at the same rotation wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inverted <= 1'b0;
        end else if (accept) begin
            inverted <= 1'b0;
        end else if ((state_q == ST_SEARCH) && !pos_hit && neg_hit) begin
            inverted <= 1'b1;
        end
    end
`else
    assign inverted = 1'b0;
`endif

endmodule
